ipv4_rx: RTL and testbench
==========================

# ipv4_rx

Receive-side IPv4 header parser sitting directly downstream of `mac_rx`, consuming its per-beat payload stream (`valid`/`start`/`data`/`len`/`crc_err`). It validates the fixed 20-byte IPv4 header, including version, IHL, fragmentation, destination address and header checksum. On a good header it forwards only the IPv4 payload, trimmed to the header's total length, to the transport layer. Everything else is dropped and reported through a one-cycle drop pulse.

## Interface
- `DATA_W`, 16: beat width in bits; legal values 16 or 32, so the 20-byte header always ends on a beat boundary.
- `LEN_W`, `$clog2(DATA_W/8)+1`: width of the byte-count fields.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `valid_i` in 1: beat valid from `mac_rx`.
- `start_i` in 1: first beat of a frame (qualified by `valid_i`).
- `data_i` in `DATA_W`: beat data; the first wire byte is in `[7:0]`.
- `len_i` in `LEN_W`: number of valid bytes in the beat.
- `crc_err_i` in 1: FCS error flag from `mac_rx`, sampled on every valid beat.
- `local_ip_i` in 32: accepted destination address, quasi-static.
- `valid_o` out 1: payload beat valid.
- `start_o` out 1: first payload beat.
- `term_o` out 1: last payload beat.
- `data_o` out `DATA_W`: payload data.
- `len_o` out `LEN_W`: valid bytes in the payload beat.
- `err_o` out 1: with `term_o`, the packet saw `crc_err_i`.
- `cancel_o` out 1: one-cycle pulse when a forwarded packet is cut short.
- `proto_o` out 8: protocol field, held from header end until the next header end.
- `src_ip_o` out 32: source address, held like `proto_o`.
- `drop_o` out 1: one-cycle pulse when a packet is rejected.
- `drop_cause_o` out 3: valid with `drop_o`.
  - 0: version != 4.
  - 1: IHL != 5.
  - 2: fragmented (MF=1 or offset != 0).
  - 3: destination mismatch.
  - 4: checksum bad.
  - 5: total length < 20.
  - 6: frame shorter than the header.

## Operation
- **Header byte order.** Header bytes are big-endian on the wire. Checksum word k = {byte 2k, byte 2k+1}.
- **Byte counter.** `byte_cnt` (16 bit) counts frame bytes; a `start_i` beat counts as bytes 0..`DATA_W/8`-1.
- **FSM states:** IDLE, HDR, PAYLOAD, DISCARD.
  - `valid_i & start_i` in any state goes to HDR and clears the counter and checksum accumulator.
  - IDLE: ignore beats without `start_i`.
  - HDR: capture bytes 0–19. Accumulate a 16-bit ones'-complement sum with end-around carry, adding `DATA_W/16` words per beat. On the beat holding byte 19, evaluate the checks in cause order; the lowest failing cause wins.
    - All pass and total_length > 20: go to PAYLOAD and latch `proto_o`/`src_ip_o`.
    - All pass and total_length == 20: go to IDLE. No output and no drop.
    - Any check fails: go to DISCARD and pulse `drop_o`.
    - Checks:
      - version must be 4 (byte0[7:4]).
      - IHL must be 5 (byte0[3:0]).
      - Fragmented means MF (byte6[5]) set or fragment offset {byte6[4:0], byte7} nonzero.
      - Destination (bytes 16–19) must equal `local_ip_i` or 32'hFFFFFFFF.
      - Final checksum sum must equal 16'hFFFF.
      - total_length ({byte2, byte3}) must be ≥ 20.
  - PAYLOAD: forward beats. Remaining = total_length − `byte_cnt`. The beat where remaining ≤ `len_i` is the last beat: `term_o`=1 and `len_o`=remaining; then go to IDLE. Bytes past total_length (Ethernet padding) are never forwarded.
  - DISCARD: swallow beats until the next `start_i`.
- **CRC error.** A sticky `crc_err` flag is set by `crc_err_i` on any valid beat of the packet, and is reported as `err_o` with `term_o`. Payload already forwarded is not retracted.
- **Frame shorter than the header.** A frame whose next `start_i` arrives, or `len_i` < `DATA_W/8`, before byte 19: `drop_o` with cause 6.
- **New start during PAYLOAD.** `cancel_o` pulses the same cycle the new header starts. No `term_o` is issued for the cut packet.
- **Beat gaps.** `valid_i` low holds all state; beats may be separated by any gap.

## Timing
- **Reset values.** After `reset` high on a `clk` edge, all outputs are 0 (`proto_o`, `src_ip_o`, `data_o`, `drop_cause_o` included) and the FSM is in IDLE. Reset mid-packet discards the packet with no `cancel_o`.
- **Registered outputs.** All outputs are registered. Latency from payload input beat to `valid_o` is 1 cycle.
- **Drop and field timing.** `drop_o` and the `proto_o`/`src_ip_o` updates appear 1 cycle after the beat holding byte 19.
- **First payload beat.** `start_o` is on the first payload beat, at the earliest 1 cycle after `drop_o` would have fired.
- **No backpressure.** The block accepts every beat. Its output beat rate equals its input beat rate.
- **Don't-care data.** `data_o` is don't-care when `valid_o`=0. Bytes at or above `len_o` are don't-care.

## Test plan
- **Good packet, aligned end.** `DATA_W`=16, valid header with total_length=28 and dst=`local_ip_i` → 4 payload beats with `len_o`=2, `start_o` on the first, `term_o` on the 4th, `err_o`=0. `proto_o` matches the header.
- **Padding trim, unaligned end.** total_length=25 in a 60-byte frame → 3 beats with `len_o`=2,2,1. `term_o` on the 3rd beat; nothing after it.
- **Bad checksum.** Same as the first scenario with the checksum byte XOR 8'h01 → `drop_o`=1 with `drop_cause_o`=4, and `valid_o` stays 0 for the whole frame.
- **Broadcast vs. mismatch.** dst=255.255.255.255 → forwarded. dst=10.0.0.9 with `local_ip_i`=10.0.0.1 → `drop_o` with cause 3.
- **Fragmented packet and CRC error.** MF=1 → `drop_o` with cause 2. A separate good packet with `crc_err_i` on the last beat → `term_o` with `err_o`=1.
- **Interruption and reset.** New `start_i` mid-payload → `cancel_o` pulse and the new header is parsed normally. `reset` mid-payload → all outputs 0 on the next cycle and no `cancel_o`.

Source files
------------

// File: rtl/ipv4_rx.sv
// Receive-side IPv4 header parser. Validates the fixed 20-byte header that
// follows mac_rx, forwards the payload trimmed to total_length, and reports
// rejected packets through a one-cycle drop pulse with a cause code.
module ipv4_rx #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = $clog2(DATA_W/8) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              crc_err_i,
  input  logic [31:0]       local_ip_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              term_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              err_o,
  output logic              cancel_o,
  output logic [7:0]        proto_o,
  output logic [31:0]       src_ip_o,
  output logic              drop_o,
  output logic [2:0]        drop_cause_o
);

  localparam int          BPB      = DATA_W / 8;
  localparam int          WPB      = DATA_W / 16;
  localparam logic [15:0] HDR_LAST = 16'(20 - BPB);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DISCARD} state_t;

  state_t      r_state;
  logic [15:0] r_byte_cnt;
  logic [15:0] r_sum;
  logic [15:0] r_tot_len;
  logic        r_crc_err;
  logic        r_first;
  logic [7:0]  r_hdr [20];

  logic        w_start;
  logic [15:0] w_base;
  logic [7:0]  w_hdr [20];
  logic [15:0] w_sum;
  logic [15:0] w_tot_len;
  logic [31:0] w_dst;
  logic        w_bad;
  logic [2:0]  w_cause;
  logic        w_short;
  logic [15:0] w_remain;
  logic        w_last;

  function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign w_start   = valid_i & start_i;
  assign w_base    = w_start ? 16'd0 : r_byte_cnt;
  assign w_tot_len = {w_hdr[2], w_hdr[3]};
  assign w_dst     = {w_hdr[16], w_hdr[17], w_hdr[18], w_hdr[19]};
  assign w_short   = len_i < LEN_W'(BPB);
  assign w_remain  = r_tot_len - r_byte_cnt;
  assign w_last    = w_remain <= 16'(len_i);

  // Header view including the bytes of the current beat, so checks can run on the last header beat.
  always_comb begin
    for (int i = 0; i < 20; i++) w_hdr[i] = r_hdr[i];
    for (int b = 0; b < BPB; b++) begin
      if (int'(w_base) + b < 20) w_hdr[int'(w_base) + b] = data_i[8*b +: 8];
    end
  end

  // Ones'-complement running sum; wire byte 2k is the high byte of word k.
  always_comb begin
    w_sum = w_start ? 16'd0 : r_sum;
    for (int w = 0; w < WPB; w++) w_sum = add1c(w_sum, {data_i[16*w +: 8], data_i[16*w+8 +: 8]});
  end

  // Header checks in cause order; the first failing check determines the cause.
  always_comb begin
    w_bad   = 1'b1;
    w_cause = 3'd0;
    if (w_hdr[0][7:4] != 4'd4)                                    w_cause = 3'd0;
    else if (w_hdr[0][3:0] != 4'd5)                               w_cause = 3'd1;
    else if (w_hdr[6][5] || ({w_hdr[6][4:0], w_hdr[7]} != 13'd0)) w_cause = 3'd2;
    else if ((w_dst != local_ip_i) && (w_dst != 32'hFFFF_FFFF))   w_cause = 3'd3;
    else if (w_sum != 16'hFFFF)                                   w_cause = 3'd4;
    else if (w_tot_len < 16'd20)                                  w_cause = 3'd5;
    else                                                          w_bad   = 1'b0;
  end

  // Header byte capture while a header is in flight.
  // NOTE: no reset here on purpose; every header byte is rewritten before the check that reads it.
  always_ff @(posedge clk) begin
    if (valid_i && (start_i || r_state == S_HDR)) begin
      for (int i = 0; i < 20; i++) r_hdr[i] <= w_hdr[i];
    end
  end

  // Parser FSM with registered outputs.
  // NOTE: all state here uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= '0;
      r_sum        <= '0;
      r_tot_len    <= '0;
      r_crc_err    <= 1'b0;
      r_first      <= 1'b0;
      valid_o      <= 1'b0;
      start_o      <= 1'b0;
      term_o       <= 1'b0;
      data_o       <= '0;
      len_o        <= '0;
      err_o        <= 1'b0;
      cancel_o     <= 1'b0;
      proto_o      <= '0;
      src_ip_o     <= '0;
      drop_o       <= 1'b0;
      drop_cause_o <= '0;
    end else begin
      valid_o  <= 1'b0;
      start_o  <= 1'b0;
      term_o   <= 1'b0;
      err_o    <= 1'b0;
      cancel_o <= 1'b0;
      drop_o   <= 1'b0;
      if (valid_i) begin
        r_crc_err <= start_i ? crc_err_i : (r_crc_err | crc_err_i);
        if (start_i) begin
          // A start inside a header means the previous frame was too short.
          if (r_state == S_PAYLOAD) cancel_o <= 1'b1;
          if (r_state == S_HDR || w_short) begin
            drop_o       <= 1'b1;
            drop_cause_o <= 3'd6;
          end
          r_byte_cnt <= 16'(BPB);
          r_sum      <= w_sum;
          r_state    <= w_short ? S_DISCARD : S_HDR;
        end else begin
          case (r_state)
            S_HDR: begin
              r_byte_cnt <= r_byte_cnt + 16'(BPB);
              r_sum      <= w_sum;
              if (w_short) begin
                drop_o       <= 1'b1;
                drop_cause_o <= 3'd6;
                r_state      <= S_DISCARD;
              end else if (r_byte_cnt == HDR_LAST) begin
                if (w_bad) begin
                  drop_o       <= 1'b1;
                  drop_cause_o <= w_cause;
                  r_state      <= S_DISCARD;
                end else if (w_tot_len == 16'd20) begin
                  r_state <= S_IDLE;
                end else begin
                  proto_o   <= w_hdr[9];
                  src_ip_o  <= {w_hdr[12], w_hdr[13], w_hdr[14], w_hdr[15]};
                  r_tot_len <= w_tot_len;
                  r_first   <= 1'b1;
                  r_state   <= S_PAYLOAD;
                end
              end
            end
            S_PAYLOAD: begin
              valid_o    <= 1'b1;
              start_o    <= r_first;
              data_o     <= data_i;
              r_first    <= 1'b0;
              r_byte_cnt <= r_byte_cnt + 16'(BPB);
              if (w_last) begin
                term_o  <= 1'b1;
                len_o   <= w_remain[LEN_W-1:0];
                err_o   <= r_crc_err | crc_err_i;
                r_state <= S_IDLE;
              end else begin
                len_o <= len_i;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ipv4_rx.sv
// Directed testbench for ipv4_rx with DATA_W=16.
module tb_ipv4_rx;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              valid_i = 1'b0;
  logic              start_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic              crc_err_i = 1'b0;
  logic [31:0]       local_ip_i = 32'h0A00_0001;
  logic              valid_o, start_o, term_o, err_o, cancel_o, drop_o;
  logic [DATA_W-1:0] data_o;
  logic [LEN_W-1:0]  len_o;
  logic [7:0]        proto_o;
  logic [31:0]       src_ip_o;
  logic [2:0]        drop_cause_o;

  ipv4_rx #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .start_i(start_i), .data_i(data_i),
    .len_i(len_i), .crc_err_i(crc_err_i), .local_ip_i(local_ip_i), .valid_o(valid_o),
    .start_o(start_o), .term_o(term_o), .data_o(data_o), .len_o(len_o), .err_o(err_o),
    .cancel_o(cancel_o), .proto_o(proto_o), .src_ip_o(src_ip_o), .drop_o(drop_o),
    .drop_cause_o(drop_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  l;
    logic        s;
    logic        t;
    logic        e;
    int          cyc;
  } beat_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          hdr_end_cyc = 0;
  int          drop_cnt = 0;
  int          drop_cyc = 0;
  int          cancel_cnt = 0;
  int          cancel_cyc = 0;
  logic [2:0]  drop_cause_last = '0;
  logic [7:0]  frm [0:63];
  beat_t       obs [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (valid_o) obs.push_back('{data_o, len_o, start_o, term_o, err_o, cyc});
    if (drop_o) begin
      drop_cnt++;
      drop_cause_last = drop_cause_o;
      drop_cyc = cyc;
    end
    if (cancel_o) begin
      cancel_cnt++;
      cancel_cyc = cyc;
    end
  end

  task automatic clear_mon();
    obs.delete();
    drop_cnt = 0;
    cancel_cnt = 0;
    drop_cause_last = '0;
  endtask

  // Builds a frame: header with a correct checksum (optionally corrupted), then payload A0, A1, ...
  task automatic build(input logic [15:0] tl, input logic [7:0] b0, input logic [7:0] b6,
                       input logic [31:0] dst, input int n, input logic [7:0] csum_xor);
    logic [31:0] s;
    logic [15:0] cs;
    frm[0] = b0;    frm[1] = 8'h00;  frm[2] = tl[15:8]; frm[3] = tl[7:0];
    frm[4] = 8'h00; frm[5] = 8'h01;  frm[6] = b6;       frm[7] = 8'h00;
    frm[8] = 8'h40; frm[9] = 8'h11;  frm[10] = 8'h00;   frm[11] = 8'h00;
    frm[12] = 8'h0A; frm[13] = 8'h00; frm[14] = 8'h00; frm[15] = 8'h02;
    frm[16] = dst[31:24]; frm[17] = dst[23:16]; frm[18] = dst[15:8]; frm[19] = dst[7:0];
    for (int i = 20; i < n; i++) frm[i] = 8'(8'hA0 + i - 20);
    s = 32'd0;
    for (int w = 0; w < 10; w++) s = s + {16'd0, frm[2*w], frm[2*w+1]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    frm[10] = cs[15:8];
    frm[11] = cs[7:0] ^ csum_xor;
  endtask

  task automatic send_frame(input int n, input int max_beats, input int crc_beat);
    int nb;
    nb = (n + 1) / 2;
    if (max_beats < nb) nb = max_beats;
    for (int j = 0; j < nb; j++) begin
      int k;
      k = 2 * j;
      @(posedge clk); #1;
      valid_i   = 1'b1;
      start_i   = (j == 0);
      data_i    = {(k + 1 < n) ? frm[k+1] : 8'h00, frm[k]};
      len_i     = (n - k >= 2) ? 2'd2 : 2'd1;
      crc_err_i = (j == crc_beat);
      if (j == 0) start_cyc = cyc;
      if (k == 18) hdr_end_cyc = cyc;
    end
  endtask

  task automatic idle(input int m);
    @(posedge clk); #1;
    valid_i   = 1'b0;
    start_i   = 1'b0;
    crc_err_i = 1'b0;
    repeat (m - 1) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({valid_o, start_o, term_o, err_o, cancel_o, drop_o} !== 6'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000", {valid_o, start_o, term_o, err_o, cancel_o, drop_o});
    end
    n_checks++;
    if ({proto_o, src_ip_o} !== 40'd0) begin
      n_fail++; $display("FAIL reset_fields: got %h expected 0", {proto_o, src_ip_o});
    end
    n_checks++;
    if ({data_o, len_o, drop_cause_o} !== 21'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {data_o, len_o, drop_cause_o});
    end
    #1 reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_aligned();
    clear_mon();
    build(16'd28, 8'h45, 8'h00, 32'h0A00_0001, 28, 8'h00);
    send_frame(28, 99, -1);
    idle(4);
    n_checks++;
    if (obs.size() != 4) begin
      n_fail++; $display("FAIL good_beats: got %0d expected 4", obs.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if ({obs[j].d, obs[j].l, obs[j].s, obs[j].t} !== {frm[21+2*j], frm[20+2*j], 2'd2, j == 0, j == 3}) begin
          n_fail++;
          $display("FAIL good_beat%0d: got d=%h l=%0d s=%b t=%b expected d=%h l=2 s=%b t=%b", j, obs[j].d,
                   obs[j].l, obs[j].s, obs[j].t, {frm[21+2*j], frm[20+2*j]}, j == 0, j == 3);
        end
      end
      n_checks++;
      if (obs[3].e !== 1'b0) begin
        n_fail++; $display("FAIL good_err: got %b expected 0", obs[3].e);
      end
      n_checks++;
      if (obs[0].cyc != hdr_end_cyc + 2) begin
        n_fail++; $display("FAIL good_first_latency: got cycle %0d expected %0d", obs[0].cyc, hdr_end_cyc + 2);
      end
    end
    n_checks++;
    if (proto_o !== 8'h11 || src_ip_o !== 32'h0A00_0002) begin
      n_fail++; $display("FAIL good_fields: got proto=%h src=%h expected proto=11 src=0a000002", proto_o, src_ip_o);
    end
    n_checks++;
    if (drop_cnt != 0) begin
      n_fail++; $display("FAIL good_no_drop: got %0d drops expected 0", drop_cnt);
    end
  endtask

  task automatic test_padding();
    clear_mon();
    build(16'd25, 8'h45, 8'h00, 32'h0A00_0001, 60, 8'h00);
    send_frame(60, 99, -1);
    idle(4);
    n_checks++;
    if (obs.size() != 3) begin
      n_fail++; $display("FAIL pad_beats: got %0d expected 3", obs.size());
    end else begin
      n_checks++;
      if ({obs[0].l, obs[1].l, obs[2].l} !== {2'd2, 2'd2, 2'd1}) begin
        n_fail++; $display("FAIL pad_lens: got %0d,%0d,%0d expected 2,2,1", obs[0].l, obs[1].l, obs[2].l);
      end
      n_checks++;
      if ({obs[0].t, obs[1].t, obs[2].t} !== 3'b001) begin
        n_fail++; $display("FAIL pad_term: got %b expected 001", {obs[0].t, obs[1].t, obs[2].t});
      end
      n_checks++;
      if (obs[2].d[7:0] !== 8'hA4) begin
        n_fail++; $display("FAIL pad_last_byte: got %h expected a4", obs[2].d[7:0]);
      end
    end
  endtask

  task automatic test_bad_csum();
    clear_mon();
    build(16'd28, 8'h45, 8'h00, 32'h0A00_0001, 28, 8'h01);
    send_frame(28, 99, -1);
    idle(4);
    n_checks++;
    if (drop_cnt != 1 || drop_cause_last !== 3'd4) begin
      n_fail++; $display("FAIL csum_drop: got %0d drops cause %0d expected 1 cause 4", drop_cnt, drop_cause_last);
    end
    n_checks++;
    if (drop_cyc != hdr_end_cyc + 1) begin
      n_fail++; $display("FAIL csum_drop_time: got cycle %0d expected %0d", drop_cyc, hdr_end_cyc + 1);
    end
    n_checks++;
    if (obs.size() != 0) begin
      n_fail++; $display("FAIL csum_no_output: got %0d beats expected 0", obs.size());
    end
  endtask

  task automatic test_dst();
    clear_mon();
    build(16'd28, 8'h45, 8'h00, 32'hFFFF_FFFF, 28, 8'h00);
    send_frame(28, 99, -1);
    idle(4);
    n_checks++;
    if (obs.size() != 4 || drop_cnt != 0) begin
      n_fail++; $display("FAIL bcast_fwd: got %0d beats %0d drops expected 4 beats 0 drops", obs.size(), drop_cnt);
    end
    clear_mon();
    build(16'd28, 8'h45, 8'h00, 32'h0A00_0009, 28, 8'h00);
    send_frame(28, 99, -1);
    idle(4);
    n_checks++;
    if (drop_cnt != 1 || drop_cause_last !== 3'd3 || obs.size() != 0) begin
      n_fail++;
      $display("FAIL dst_mismatch: got %0d drops cause %0d beats %0d expected 1 cause 3 beats 0",
               drop_cnt, drop_cause_last, obs.size());
    end
  endtask

  task automatic test_header_fields();
    logic [7:0] b0_tab [4] = '{8'h65, 8'h46, 8'h66, 8'h45};
    logic [15:0] tl_tab [4] = '{16'd28, 16'd28, 16'd28, 16'd19};
    logic [7:0] x_tab [4] = '{8'h00, 8'h00, 8'h01, 8'h00};
    logic [2:0] exp_tab [4] = '{3'd0, 3'd1, 3'd0, 3'd5};
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      build(tl_tab[i], b0_tab[i], 8'h00, 32'h0A00_0001, 28, x_tab[i]);
      send_frame(28, 99, -1);
      idle(4);
      n_checks++;
      if (drop_cnt != 1 || drop_cause_last !== exp_tab[i] || obs.size() != 0) begin
        n_fail++;
        $display("FAIL hdr_case%0d: got %0d drops cause %0d beats %0d expected 1 cause %0d beats 0",
                 i, drop_cnt, drop_cause_last, obs.size(), exp_tab[i]);
      end
    end
    // Frame ending mid-header with a partial beat.
    clear_mon();
    build(16'd28, 8'h45, 8'h00, 32'h0A00_0001, 28, 8'h00);
    send_frame(11, 99, -1);
    idle(4);
    n_checks++;
    if (drop_cnt != 1 || drop_cause_last !== 3'd6) begin
      n_fail++; $display("FAIL short_len: got %0d drops cause %0d expected 1 cause 6", drop_cnt, drop_cause_last);
    end
    // Header cut by a new start, followed by a good packet.
    clear_mon();
    send_frame(28, 5, -1);
    send_frame(28, 99, -1);
    idle(4);
    n_checks++;
    if (drop_cnt != 1 || drop_cause_last !== 3'd6 || obs.size() != 4) begin
      n_fail++;
      $display("FAIL short_restart: got %0d drops cause %0d beats %0d expected 1 cause 6 beats 4",
               drop_cnt, drop_cause_last, obs.size());
    end
  endtask

  task automatic test_frag_crc();
    clear_mon();
    build(16'd28, 8'h45, 8'h20, 32'h0A00_0001, 28, 8'h00);
    send_frame(28, 99, -1);
    idle(4);
    n_checks++;
    if (drop_cnt != 1 || drop_cause_last !== 3'd2) begin
      n_fail++; $display("FAIL frag_mf: got %0d drops cause %0d expected 1 cause 2", drop_cnt, drop_cause_last);
    end
    clear_mon();
    build(16'd28, 8'h45, 8'h01, 32'h0A00_0001, 28, 8'h00);
    send_frame(28, 99, -1);
    idle(4);
    n_checks++;
    if (drop_cnt != 1 || drop_cause_last !== 3'd2) begin
      n_fail++; $display("FAIL frag_offset: got %0d drops cause %0d expected 1 cause 2", drop_cnt, drop_cause_last);
    end
    clear_mon();
    build(16'd28, 8'h45, 8'h00, 32'h0A00_0001, 28, 8'h00);
    send_frame(28, 99, 13);
    idle(4);
    n_checks++;
    if (obs.size() != 4) begin
      n_fail++; $display("FAIL crc_beats: got %0d expected 4", obs.size());
    end else if ({obs[3].t, obs[3].e, obs[0].e} !== 3'b110) begin
      n_fail++; $display("FAIL crc_err: got t=%b e=%b e0=%b expected t=1 e=1 e0=0", obs[3].t, obs[3].e, obs[0].e);
    end
  endtask

  task automatic test_back_to_back();
    int terms;
    clear_mon();
    build(16'd28, 8'h45, 8'h00, 32'h0A00_0001, 28, 8'h00);
    send_frame(28, 12, -1);
    send_frame(28, 99, -1);
    idle(4);
    terms = 0;
    foreach (obs[j]) if (obs[j].t) terms++;
    n_checks++;
    if (cancel_cnt != 1 || cancel_cyc != start_cyc + 1) begin
      n_fail++;
      $display("FAIL cancel_pulse: got %0d pulses at cycle %0d expected 1 at %0d", cancel_cnt, cancel_cyc, start_cyc + 1);
    end
    n_checks++;
    if (obs.size() != 6 || terms != 1) begin
      n_fail++; $display("FAIL cancel_beats: got %0d beats %0d terms expected 6 beats 1 term", obs.size(), terms);
    end else if (obs[2].s !== 1'b1 || obs[5].t !== 1'b1 || obs[1].t !== 1'b0) begin
      n_fail++; $display("FAIL cancel_reparse: got s2=%b t5=%b t1=%b expected 1 1 0", obs[2].s, obs[5].t, obs[1].t);
    end
    n_checks++;
    if (drop_cnt != 0) begin
      n_fail++; $display("FAIL cancel_no_drop: got %0d drops expected 0", drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    build(16'd28, 8'h45, 8'h00, 32'h0A00_0001, 28, 8'h00);
    send_frame(28, 11, -1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    start_i = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs.size() != 1) begin
      n_fail++; $display("FAIL rstmid_pre: got %0d beats before reset expected 1", obs.size());
    end
    n_checks++;
    if ({valid_o, start_o, term_o, err_o, cancel_o, drop_o, proto_o, src_ip_o, data_o, len_o, drop_cause_o} !== 67'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got v=%b proto=%h src=%h data=%h expected all 0", valid_o, proto_o, src_ip_o, data_o);
    end
    #1 reset = 1'b0;
    idle(3);
    send_frame(28, 99, -1);
    idle(4);
    n_checks++;
    if (cancel_cnt != 0 || obs.size() != 5) begin
      n_fail++; $display("FAIL rstmid_after: got %0d cancels %0d beats expected 0 cancels 5 beats", cancel_cnt, obs.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_aligned();
    test_padding();
    test_bad_csum();
    test_dst();
    test_header_fields();
    test_frag_crc();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
